cmp_arbiter: RTL and testbench
==============================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 6 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 wants a comparison; held until gnt0.
REQ-005 a0, b0  input  6 each  requester 0 operands; stable while req0 high.
REQ-006 mode0  input  1  requester 0 op: 0 = equal test, 1 = differ test.
REQ-007 req1, a1, b1, mode1  input  1/6/6/1  requester 1, same meaning as requester 0.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-009 res_valid  output  1  result available.
REQ-010 res_value  output  1  comparison result.
REQ-011 res_id  output  1  requester that owns the result (0 or 1).
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  8  number of results accepted by the consumer.

Function
REQ-015 The FSM SHALL have three states, IDLE, EXEC and DONE, encoded in 2 bits.
REQ-016 In IDLE, with req0 or req1 high at a rising edge, the block SHALL move to EXEC and latch the winner's a, b, mode and id at that edge.
REQ-017 In IDLE with no request, the block SHALL stay in IDLE.
REQ-018 The matching gntN SHALL be high for exactly the EXEC cycle; the other grant stays low.
REQ-019 Arbitration SHALL be round-robin: a 1-bit pointer names the last requester served, and the other requester wins when both request.
REQ-020 With only one request active, that requester SHALL win regardless of the pointer.
REQ-021 At the edge that ends EXEC, the block SHALL register the result and move to DONE with res_valid=1.
REQ-022 The result SHALL be: mode=0 gives 1 iff all 6 bits of a equal b; mode=1 gives 1 iff any of the 6 bits differs.
REQ-023 In DONE, res_valid, res_value and res_id SHALL hold stable until res_ready is sampled high.
REQ-024 When res_ready is sampled high in DONE, at that edge the block SHALL:
  - clear res_valid;
  - set the pointer to res_id;
  - increment op_count modulo 256 (255 wraps to 0);
  - return to IDLE.
REQ-025 res_ready outside DONE SHALL be ignored.
REQ-026 Request-to-grant latency SHALL be 1 cycle from sampling in IDLE, and request-to-res_valid latency 2 cycles.
REQ-027 Minimum issue interval SHALL be 3 cycles (IDLE, EXEC, DONE) when res_ready is held high.
REQ-028 Requests arriving in EXEC or DONE SHALL be ignored until IDLE; no request is lost while it stays held.
REQ-029 Deassertion of req or changes to operands after the latch edge SHALL NOT affect the result in flight.
REQ-030 A requester SHALL NOT receive a second grant for one req assertion unless req is still high when IDLE is next re-entered; holding req high means a new request.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
  - state to IDLE;
  - gnt0, gnt1, res_valid, res_value, res_id and busy to 0;
  - op_count to 0;
  - the pointer to 1, so requester 0 has first priority.
REQ-032 Reset in EXEC or DONE SHALL discard the in-flight operation without updating op_count.
REQ-033 After rst_n rises, the first edge SHALL behave as IDLE.

Verification
REQ-034 After reset, req0=1, a0=b0=6'b000101, mode0=0, res_ready=1 -> gnt0 pulses in cycle 1; res_valid=1, res_value=1, res_id=0 in cycle 2; op_count=1 after.
REQ-035 req1=1, a1=6'b001101, b1=6'b000101, mode1=0 -> res_value=0; same operands with mode1=1 -> res_value=1.
REQ-036 req0 and req1 held high together from reset, res_ready=1 -> grants alternate gnt0, gnt1, gnt0, gnt1, one per 3 cycles; res_id alternates 0, 1, 0, 1.
REQ-037 Operands differing only in bit 5 (a=6'b100000, b=6'b000000), mode=0 -> res_value=0.
REQ-038 res_ready=0 for 5 cycles in DONE -> res_valid and res_value stable and no new grant; res_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low during EXEC -> outputs 0 immediately; op_count unchanged at 0; first grant after release goes to requester 0.
REQ-040 256 accepted operations -> op_count wraps to 0.

Source files
------------

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: requester, result and status signals of cmp_arbiter
interface cmp_arbiter_if;
    logic       req0;
    logic [5:0] a0;
    logic [5:0] b0;
    logic       mode0;
    logic       req1;
    logic [5:0] a1;
    logic [5:0] b1;
    logic       mode1;
    logic       gnt0;
    logic       gnt1;
    logic       res_valid;
    logic       res_value;
    logic       res_id;
    logic       res_ready;
    logic       busy;
    logic [7:0] op_count;

    modport master (
        output req0, a0, b0, mode0, req1, a1, b1, mode1, res_ready,
        input  gnt0, gnt1, res_valid, res_value, res_id, busy, op_count
    );

    modport slave (
        input  req0, a0, b0, mode0, req1, a1, b1, mode1, res_ready,
        output gnt0, gnt1, res_valid, res_value, res_id, busy, op_count
    );
endinterface

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin two-requester 6-bit equal/differ comparator
module cmp_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    cmp_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [5:0] a_q, a_d;
    logic [5:0] b_q, b_d;
    logic       mode_q, mode_d;
    logic       id_q, id_d;
    logic       ptr_q, ptr_d;
    logic       res_valid_q, res_valid_d;
    logic       res_value_q, res_value_d;
    logic [7:0] op_count_q, op_count_d;
    logic       win;

    // A lone requester always wins; with both pending, the one not served last wins
    assign win = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;

    // State, latched operands, result and counters; pointer resets to 1 so requester 0 goes first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b1;
            res_valid_q <= 1'b0;
            res_value_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_value_q <= res_value_d;
            op_count_q  <= op_count_d;
        end
    end

    // Next state: latch winner in IDLE, compute result in EXEC, retire on res_ready in DONE
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        mode_d      = mode_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_value_d = res_value_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = EXEC;
                    id_d    = win;
                    a_d     = win ? bus.a1 : bus.a0;
                    b_d     = win ? bus.b1 : bus.b0;
                    mode_d  = win ? bus.mode1 : bus.mode0;
                end
            end
            EXEC: begin
                state_d     = DONE;
                res_valid_d = 1'b1;
                res_value_d = mode_q ? (a_q != b_q) : (a_q == b_q);
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    ptr_d       = id_q;
                    op_count_d  = op_count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt0      = (state_q == EXEC) && !id_q;
    assign bus.gnt1      = (state_q == EXEC) && id_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_value = res_value_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed stimulus with a transaction-level reference model for cmp_arbiter
module tb_cmp_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    int         age = -1;
    logic       m_id = 1'b0;
    logic       m_val = 1'b0;
    logic       m_ptr = 1'b1;
    logic [7:0] m_cnt = '0;

    cmp_arbiter_if bus();

    cmp_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // age: -1 idle, 0 the grant cycle, >=1 cycles spent holding a result
    task automatic model_step();
        logic pick;
        if (!rst_n) begin
            age   = -1;
            m_ptr = 1'b1;
            m_cnt = '0;
        end else if (age < 0) begin
            if (bus.req0 || bus.req1) begin
                pick  = (bus.req0 && bus.req1) ? !m_ptr : bus.req1;
                m_id  = pick;
                m_val = pick ? (bus.mode1 ? (bus.a1 != bus.b1) : (bus.a1 == bus.b1))
                             : (bus.mode0 ? (bus.a0 != bus.b0) : (bus.a0 == bus.b0));
                age   = 0;
            end
        end else if (age == 0) begin
            age = 1;
        end else if (bus.res_ready) begin
            m_ptr = m_id;
            m_cnt = m_cnt + 8'd1;
            age   = -1;
        end else begin
            age++;
        end
    endtask

    task automatic compare_all();
        chk("m_gnt0", bus.gnt0, (age == 0 && !m_id));
        chk("m_gnt1", bus.gnt1, (age == 0 && m_id));
        chk("m_res_valid", bus.res_valid, (age >= 1));
        chk("m_busy", bus.busy, (age >= 0));
        chk("m_op_count", bus.op_count, m_cnt);
        if (age >= 1) begin
            chk("m_res_value", bus.res_value, m_val);
            chk("m_res_id", bus.res_id, m_id);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.op_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_op(input logic id, input logic [5:0] a, input logic [5:0] b,
                          input logic mode, input logic expv);
        if (id) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.mode1 = mode;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.mode0 = mode;
        end
        tick();
        chk("op_gnt_mine", id ? bus.gnt1 : bus.gnt0, 1);
        chk("op_gnt_other", id ? bus.gnt0 : bus.gnt1, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = ~bus.a0;
        bus.a1 = ~bus.a1;
        tick();
        chk("op_valid", bus.res_valid, 1);
        chk("op_value", bus.res_value, expv);
        chk("op_id", bus.res_id, id);
        tick();
        chk("op_valid_clr", bus.res_valid, 0);
    endtask

    initial begin
        bus.req0 = 0; bus.a0 = 0; bus.b0 = 0; bus.mode0 = 0;
        bus.req1 = 0; bus.a1 = 0; bus.b1 = 0; bus.mode1 = 0;
        bus.res_ready = 1'b1;
        do_reset();

        run_op(1'b0, 6'b000101, 6'b000101, 1'b0, 1'b1);
        chk("count_after_first", bus.op_count, 1);
        run_op(1'b1, 6'b001101, 6'b000101, 1'b0, 1'b0);
        run_op(1'b1, 6'b001101, 6'b000101, 1'b1, 1'b1);
        run_op(1'b0, 6'b100000, 6'b000000, 1'b0, 1'b0);
        run_op(1'b1, 6'b111111, 6'b111111, 1'b1, 1'b0);
        chk("count_after_five", bus.op_count, 5);

        bus.res_ready = 1'b0;
        bus.req0 = 1'b1; bus.a0 = 6'd7; bus.b0 = 6'd3; bus.mode0 = 1'b1;
        tick();
        chk("stall_gnt0", bus.gnt0, 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", bus.res_valid, 1);
            chk("stall_value", bus.res_value, 1);
            chk("stall_no_gnt1", bus.gnt1, 0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("stall_release_busy", bus.busy, 0);
        chk("stall_count", bus.op_count, 6);
        tick();
        chk("held_req1_gnt", bus.gnt1, 1);
        bus.req1 = 1'b0;
        tick();
        tick();

        do_reset();
        bus.req0 = 1'b1; bus.a0 = 6'd9; bus.b0 = 6'd9; bus.mode0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = 6'd9; bus.b1 = 6'd8; bus.mode1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("rr_gnt0", bus.gnt0, (k % 6 == 1));
            chk("rr_gnt1", bus.gnt1, (k % 6 == 4));
            if (k % 3 == 2) chk("rr_id", bus.res_id, (k % 6 == 2) ? 0 : 1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        chk("pre_rst_gnt0", bus.gnt0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_gnt0", bus.gnt0, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_count", bus.op_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_gnt0", bus.gnt0, 1);
        chk("post_rst_gnt1", bus.gnt1, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        chk("post_rst_count", bus.op_count, 1);

        do_reset();
        bus.req0 = 1'b1; bus.a0 = 6'd1; bus.b0 = 6'd2; bus.mode0 = 1'b1;
        for (int i = 0; i < 765; i++) tick();
        chk("wrap_255", bus.op_count, 255);
        for (int i = 0; i < 3; i++) tick();
        chk("wrap_0", bus.op_count, 0);
        bus.req0 = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
